// File: rtl/gmem_sched.sv
// gmem_sched
//   Shares the single graphics-memory port between VGA scanout reads and
//   buffered CPU framebuffer writes. Scanout reads always win the port and
//   return data with a fixed two-cycle latency. CPU writes wait in a small
//   FIFO and drain into the cycles scanout leaves idle.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   scan_req/addr     scanout read request and address
//   scan_dat/vld      scanout read data (mem_rdat gated by scan_vld)
//   wr_req/addr/dat   CPU write request; accepted when wr_ready is high
//   wr_ready          FIFO not full (combinational compare of registered level)
//   mem_addr/wdat/we  registered gmem port controls
//   mem_rdat          gmem read data, one cycle after mem_addr
//   fifo_level        current write-FIFO occupancy
//   starve            queued writes denied the port for STARVE_LIMIT cycles
module gmem_sched #(
    parameter int unsigned AW           = 17,
    parameter int unsigned DW           = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 800
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scan_req,
    input  logic [AW-1:0]            scan_addr,
    output logic [DW-1:0]            scan_dat,
    output logic                     scan_vld,
    input  logic                     wr_req,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_dat,
    output logic                     wr_ready,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdat,
    output logic                     mem_we,
    input  logic [DW-1:0]            mem_rdat,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     starve
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [IW:0]   FULL_LVL = (IW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_SCAN,
        GNT_WR
    } gnt_t;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_dat  [DEPTH];
    logic [IW:0]   wptr;
    logic [IW:0]   rptr;
    logic          push;
    logic          pop;
    gnt_t          gnt_d;
    gnt_t          gnt_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;

    assign wr_ready = (fifo_level != FULL_LVL);
    assign push     = wr_req & wr_ready;
    assign pop      = (gnt_d == GNT_WR);
    assign scan_dat = scan_vld ? mem_rdat : '0;

    // Grant uses the registered level, so a word pushed into an empty FIFO
    // cannot be granted until the cycle after it lands in storage.
    always_comb begin
        gnt_d = GNT_NONE;
        if (scan_req) begin
            gnt_d = GNT_SCAN;
        end else if (fifo_level != '0) begin
            gnt_d = GNT_WR;
        end
    end

    always_comb begin
        cnt_d = cnt;
        if (fifo_level == '0 || pop) begin
            cnt_d = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_d = cnt + CW'(1);
        end
    end

    // FIFO storage needs no reset: entries are only read below the level.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr[IW-1:0]] <= wr_addr;
            fifo_dat[wptr[IW-1:0]]  <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            gnt_q      <= GNT_NONE;
            mem_addr   <= '0;
            mem_wdat   <= '0;
            mem_we     <= 1'b0;
            scan_vld   <= 1'b0;
            cnt        <= '0;
            starve     <= 1'b0;
        end else begin
            gnt_q <= gnt_d;

            if (push) begin
                wptr <= wptr + (IW + 1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (IW + 1)'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (IW + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (IW + 1)'(1);
                default: ;
            endcase

            mem_we <= pop;
            case (gnt_d)
                GNT_SCAN: mem_addr <= scan_addr;
                GNT_WR: begin
                    mem_addr <= fifo_addr[rptr[IW-1:0]];
                    mem_wdat <= fifo_dat[rptr[IW-1:0]];
                end
                default: ;
            endcase

            // Second read stage: aligns with mem_rdat one cycle after mem_addr.
            scan_vld <= (gnt_q == GNT_SCAN);

            cnt    <= cnt_d;
            starve <= (cnt_d == CNT_MAX);
        end
    end

endmodule
